muldiv_hilo_sequencer: RTL and testbench
========================================

# muldiv_hilo_sequencer

Sequencer for the multiply/divide resource and the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU issue requests from decode, runs a 32-iteration radix-2 shift-add multiply or restoring divide on private working registers, then commits the result to HI/LO. It also services MTHI/MTLO writes (the control unit's `HI_write`/`LO_write`) and MFHI/MFLO reads, and raises `stall` whenever the pipeline touches HI/LO or issues a new operation while an operation is in flight.

## Interface
- `WIDTH`, 32, operand, HI and LO width; iteration count equals `WIDTH`.
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: issue request for a mult/div, valid for one cycle.
- `op` input 2: operation select. 00 = MULTU, 01 = MULT, 10 = DIVU, 11 = DIV.
- `rs_data` input WIDTH: multiplicand or dividend.
- `rt_data` input WIDTH: multiplier or divisor.
- `hi_write` input 1: MTHI request.
- `lo_write` input 1: MTLO request.
- `wdata` input WIDTH: data for MTHI/MTLO.
- `hilo_read` input 1: MFHI or MFLO is in decode.
- `hi` output WIDTH: committed HI register.
- `lo` output WIDTH: committed LO register.
- `busy` output 1: high when the state is not IDLE.
- `stall` output 1: combinational; `busy & (start | hi_write | lo_write | hilo_read)`.
- `done` output 1: one-cycle pulse after a commit.

## Operation
States are IDLE, RUN and FIXUP.

**IDLE**
- `start` latches `op` and the operand magnitudes. For signed ops the magnitude is the two's-complement absolute value; 0x80000000 maps to unsigned 0x80000000.
- It also latches the sign flags and clears the iteration counter.
- Next state is RUN. The exception is a divide with `rt_data == 0`, which goes straight to FIXUP with a div-by-zero flag set.
- `hi_write` or `lo_write` without `start` loads `wdata` into `hi`/`lo` on the edge. Both may be written in the same cycle.
- `start` together with `hi_write`/`lo_write` in the same cycle: `start` has priority and the writes are dropped.

**RUN**
- Performs one iteration per cycle.
- Multiply: a 2*WIDTH accumulator does shift-add over the multiplier bits, LSB first.
- Divide: restoring step. Shift the {remainder, quotient} pair left by 1, subtract the divisor, restore if the result is negative, and set the quotient LSB when it is not.
- After `WIDTH` iterations (counter reaches WIDTH-1), the next state is FIXUP.
- `start`, `hi_write` and `lo_write` are ignored here; the stalled pipeline re-presents them later.

**FIXUP**
- Applies the sign correction, commits to `hi`/`lo`, pulses `done` and returns to IDLE.
- MULT: if the operand signs differ, negate the 64-bit product. HI = upper word, LO = lower word.
- DIV quotient: negated if the operand signs differ.
- DIV remainder: takes the sign of the dividend.
- DIV 0x80000000 / -1 gives LO = 0x80000000, HI = 0.
- Divide by zero (signed or unsigned): HI = `rs_data` as latched, LO = all ones.
- `hi` and `lo` never show partial results; they change only at the FIXUP commit or on an MTHI/MTLO write.

**Reset** (asynchronous, any state): state = IDLE; `hi`, `lo`, the working registers and the counter are cleared; `busy` = 0; `done` = 0.

## Timing
- `start` is sampled at edge E0.
- `busy` is high from after E0 until after E(WIDTH+1); that is 33 cycles for WIDTH = 32.
- Normal op: RUN occupies edges E1..E32 and the commit happens at E33. `hi`, `lo` and `done` are valid in the cycle after E33.
- Divide by zero: the commit happens at E1, so `busy` is high for exactly one cycle.
- `done` is high for one cycle only. `busy` is low in that same cycle.
- The cycle after commit is IDLE, so a back-to-back `start` is accepted with no gap.
- `stall` is purely combinational from `busy` and the request inputs. No request is stalled while in IDLE.
- An MTHI/MTLO write in IDLE is visible on `hi`/`lo` the next cycle.

## Test plan
- Reset, then `start` MULTU with rs = rt = 0xFFFFFFFF:
  - `busy` high for 33 cycles.
  - Then HI = 0xFFFFFFFE, LO = 0x00000001, with a single `done` pulse.
- MULT -3 × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- DIV -7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 100 / 7 → LO = 14, HI = 2.
- DIVU 0x1234 / 0:
  - `busy` high for 1 cycle.
  - HI = 0x00001234, LO = 0xFFFFFFFF.
- MULT in flight; assert `hilo_read` and `hi_write` (wdata 0xAAAA) at cycle 5:
  - `stall` = 1 through the last busy cycle.
  - `hi` holds its pre-op value until commit; the write is dropped.
  - After the pipeline re-presents `hi_write` in IDLE, `hi` = 0xAAAA.
- Start MULTU 5 × 5, drop `reset_n` at cycle 10:
  - `hi` = `lo` = 0 and `busy` = 0 immediately.
  - No `done` pulse.
  - After release, a new MULTU 5 × 5 gives LO = 25.

Source files
------------

// File: rtl/muldiv_hilo_sequencer.sv
// Multiply/divide sequencer owning the HI/LO pair: radix-2 shift-add multiply
// and restoring divide on magnitudes, sign-corrected and committed in FIXUP.
module muldiv_hilo_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_write,
    input  logic             lo_write,
    input  logic [WIDTH-1:0] wdata,
    input  logic             hilo_read,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

    state_t             state, state_nxt;
    logic [1:0]         op_q;
    logic               sign_a, sign_b, div0;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH-1:0]   mag_rs, mag_rt;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_top, div_diff;
    logic [2*WIDTH-1:0] acc_step, prod;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               rt_zero;

    assign rt_zero = (rt_data == '0);
    assign mag_rs  = (op[0] && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    assign mag_rt  = (op[0] && rt_data[WIDTH-1]) ? -rt_data : rt_data;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (op[1] && rt_zero) ? FIXUP : RUN;
            RUN:     if (cnt == CW'(WIDTH-1)) state_nxt = FIXUP;
            FIXUP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy  = (state != IDLE);
    assign stall = busy & (start | hi_write | lo_write | hilo_read);

    // Multiply keeps {partial product, remaining multiplier}; divide keeps
    // {remainder, quotient}. The trial difference is bounded by the divisor,
    // so WIDTH+1 signed bits are enough to detect a negative result.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_top  = acc[2*WIDTH-1:WIDTH-1];
        div_diff = div_top - {1'b0, opnd};
        if (op_q[1]) begin
            if (div_diff[WIDTH]) acc_step = {div_top[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else                 acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod   = (sign_a ^ sign_b) ? -acc : acc;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (div0) begin
            res_hi = acc[2*WIDTH-1:WIDTH];
            res_lo = acc[WIDTH-1:0];
        end else if (op_q[1]) begin
            res_lo = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            res_hi = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q   <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            div0   <= 1'b0;
            cnt    <= '0;
            opnd   <= '0;
            acc    <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= (state == FIXUP);
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        sign_a <= op[0] & rs_data[WIDTH-1];
                        sign_b <= op[0] & rt_data[WIDTH-1];
                        cnt    <= '0;
                        div0   <= op[1] & rt_zero;
                        opnd   <= op[1] ? mag_rt : mag_rs;
                        // Divide-by-zero parks the final HI/LO image in acc directly
                        if (op[1] && rt_zero) acc <= {rs_data, {WIDTH{1'b1}}};
                        else if (op[1])       acc <= {{WIDTH{1'b0}}, mag_rs};
                        else                  acc <= {{WIDTH{1'b0}}, mag_rt};
                    end else begin
                        if (hi_write) hi <= wdata;
                        if (lo_write) lo <= wdata;
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                end
                FIXUP: begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_sequencer.sv
// Scoreboard bench: expected HI/LO and busy length are queued at issue and
// compared by a monitor on every done pulse; model uses plain 64-bit arithmetic.
module tb_muldiv_hilo_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        hi_write = 1'b0;
    logic        lo_write = 1'b0;
    logic [31:0] wdata = '0;
    logic        hilo_read = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, stall, done;

    muldiv_hilo_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .hi_write(hi_write),
        .lo_write(lo_write), .wdata(wdata), .hilo_read(hilo_read),
        .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cycles;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned busy_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      sa, sb_, q, r;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        e.cycles = 33;
        case (o)
            2'd0: p = {32'b0, a} * {32'b0, b};
            2'd1: p = sa * sb_;
            default: begin
                if (b == 0) begin
                    p = {a, 32'hFFFF_FFFF};
                    e.cycles = 1;
                end else if (o == 2'd2) begin
                    p = {a % b, a / b};
                end else begin
                    q = sa / sb_;
                    r = sa % sb_;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        e.hi = p[63:32];
        e.lo = p[31:0];
        return e;
    endfunction

    // Monitor: compares every committed result against the oldest expectation
    always @(negedge clk) begin
        if (!reset_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL done_unexpected: got done=1 expected no pending op");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result_hi", 64'(hi), 64'(e.hi));
                    check("result_lo", 64'(lo), 64'(e.lo));
                    check("busy_cycles", 64'(busy_cnt), 64'(e.cycles));
                    check("busy_low_at_done", 64'(busy), 64'(0));
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        sb.push_back(model(o, a, b));
        op = o;
        rs_data = a;
        rt_data = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #1;
            seen = done;
        end
        check("done_within_bound", 64'(seen), 64'(1));
    endtask

    initial begin
        logic [31:0] pre_hi, pre_lo, a, b;
        logic [1:0]  o;
        logic        seen;

        repeat (2) @(posedge clk);
        #1;
        check("reset_hi", 64'(hi), 64'(0));
        check("reset_lo", 64'(lo), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed ops, issued back-to-back in each done cycle
        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done();
        issue(2'd1, -32'sd3, 32'd7);               wait_done();
        issue(2'd3, -32'sd7, 32'd2);               wait_done();
        issue(2'd2, 32'd100, 32'd7);               wait_done();
        issue(2'd2, 32'h1234, 32'd0);              wait_done();
        issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();
        issue(2'd3, 32'hFFFF_FFF0, 32'd0);         wait_done();
        @(posedge clk); #1;

        // MTHI/MTLO in IDLE, both and then one
        hi_write = 1'b1; lo_write = 1'b1; wdata = 32'h5A5A_0001;
        @(posedge clk); #1;
        hi_write = 1'b0; lo_write = 1'b0;
        check("mt_both_hi", 64'(hi), 64'h5A5A_0001);
        check("mt_both_lo", 64'(lo), 64'h5A5A_0001);
        check("idle_stall", 64'(stall), 64'(0));
        lo_write = 1'b1; wdata = 32'h0000_BEEF;
        @(posedge clk); #1;
        lo_write = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h0000_BEEF);
        check("mtlo_hi_kept", 64'(hi), 64'h5A5A_0001);

        // start beats a same-cycle write; later requests stall and are dropped
        pre_hi = hi;
        pre_lo = lo;
        hi_write = 1'b1; lo_write = 1'b1; wdata = 32'hDEAD_DEAD;
        issue(2'd1, 32'h0001_2345, -32'sd999);
        hi_write = 1'b0; lo_write = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        hilo_read = 1'b1; hi_write = 1'b1; wdata = 32'h0000_AAAA;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #1;
            seen = done;
            if (!seen) begin
                check("stall_while_busy", 64'(stall), 64'(1));
                check("hi_held", 64'(hi), 64'(pre_hi));
                check("lo_held", 64'(lo), 64'(pre_lo));
            end
        end
        check("stall_op_done", 64'(seen), 64'(1));
        check("stall_after_busy", 64'(stall), 64'(0));
        @(posedge clk); #1;
        hilo_read = 1'b0; hi_write = 1'b0;
        check("mthi_replayed", 64'(hi), 64'h0000_AAAA);

        // Asynchronous reset mid-operation aborts without a done pulse
        issue(2'd0, 32'd5, 32'd5);
        repeat (9) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        #1;
        check("abort_hi", 64'(hi), 64'(0));
        check("abort_lo", 64'(lo), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        sb.delete();
        @(posedge clk); #1;
        check("abort_no_done", 64'(done), 64'(0));
        reset_n = 1'b1;
        @(posedge clk); #1;
        issue(2'd0, 32'd5, 32'd5);
        wait_done();
        check("post_reset_lo", 64'(lo), 64'd25);

        // Randomized ops against the reference model
        for (int n = 0; n < 24; n++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 20));
            if ($urandom_range(0, 1) == 0 && b < 32'd21) b = -b;
            if ($urandom_range(0, 5) == 0) b = '0;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            issue(o, a, b);
            wait_done();
        end
        @(posedge clk); #1;
        check("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
